// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
// Optional feature macro used by the top: MEM_ARB_PERF_EN (stall-cycle counters).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_e;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int MEM_LAT_DEF = 2;
  localparam int PERF_W      = 32;

  // Latency counter must hold MEM_LAT-1; keep at least one bit.
  function automatic int cnt_width(input int lat);
    return (lat < 2) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Loadable down-counter that flags when the memory latency window has elapsed.
module mem_arb_timer #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Saturates at zero so done stays asserted while idle.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and data ports onto one single-ported multi-cycle memory.
// Define MEM_ARB_PERF_EN to build the per-port stall-cycle counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ireq,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] irdata,
  output logic              iready,
  output logic              istall,
  input  logic              dreq,
  input  logic              dwe,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dwdata,
  output logic [DATA_W-1:0] drdata,
  output logic              dready,
  output logic              dstall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [PERF_W-1:0] perf_istall,
  output logic [PERF_W-1:0] perf_dstall
);

  localparam int              CNT_W    = cnt_width(MEM_LAT);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            lg_q, lg_d;
  logic              we_q, we_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] irdata_q, irdata_d;
  logic [DATA_W-1:0] drdata_q, drdata_d;
  logic              iready_q, iready_d;
  logic              dready_q, dready_d;
  logic              grant;
  logic              timer_done;

  mem_arb_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (grant),
    .load_val_i (LAT_LOAD),
    .done_o     (timer_done)
  );

  // Under contention D wins unless it won last time, giving strict alternation.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lg_d        = lg_q;
    we_d        = we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    irdata_d    = irdata_q;
    drdata_d    = drdata_q;
    iready_d    = 1'b0;
    dready_d    = 1'b0;
    grant       = 1'b0;
    case (state_q)
      IDLE: begin
        if (dreq && (!ireq || lg_q != OWN_D)) begin
          grant       = 1'b1;
          owner_d     = OWN_D;
          lg_d        = OWN_D;
          we_d        = dwe;
          mem_en_d    = 1'b1;
          mem_we_d    = dwe;
          mem_addr_d  = daddr;
          mem_wdata_d = dwdata;
          state_d     = BUSY;
        end else if (ireq) begin
          grant       = 1'b1;
          owner_d     = OWN_I;
          lg_d        = OWN_I;
          we_d        = 1'b0;
          mem_en_d    = 1'b1;
          mem_addr_d  = iaddr;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (timer_done) begin
          state_d = DONE;
          if (owner_q == OWN_D) begin
            dready_d = 1'b1;
            if (!we_q) begin
              drdata_d = mem_rdata;
            end
          end else begin
            iready_d = 1'b1;
            irdata_d = mem_rdata;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      lg_q        <= OWN_I;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      irdata_q    <= '0;
      drdata_q    <= '0;
      iready_q    <= 1'b0;
      dready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lg_q        <= lg_d;
      we_q        <= we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      irdata_q    <= irdata_d;
      drdata_q    <= drdata_d;
      iready_q    <= iready_d;
      dready_q    <= dready_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign irdata    = irdata_q;
  assign drdata    = drdata_q;
  assign iready    = iready_q;
  assign dready    = dready_q;
  assign istall    = ireq & ~iready_q;
  assign dstall    = dreq & ~dready_q;

`ifdef MEM_ARB_PERF_EN
  logic [PERF_W-1:0] perf_i_q, perf_i_d;
  logic [PERF_W-1:0] perf_d_q, perf_d_d;

  assign perf_i_d = perf_i_q + PERF_W'(istall);
  assign perf_d_d = perf_d_q + PERF_W'(dstall);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_i_q <= '0;
      perf_d_q <= '0;
    end else begin
      perf_i_q <= perf_i_d;
      perf_d_q <= perf_d_d;
    end
  end

  assign perf_istall = perf_i_q;
  assign perf_dstall = perf_d_q;
`else
  assign perf_istall = '0;
  assign perf_dstall = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-timing model plus directed literal checks.
module tb_mem_arbiter;

  localparam int LAT = 2;

  logic        clk;
  logic        rst;
  logic        ireq;
  logic [31:0] iaddr;
  logic [31:0] irdata;
  logic        iready;
  logic        istall;
  logic        dreq;
  logic        dwe;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [31:0] drdata;
  logic        dready;
  logic        dstall;
  logic        memEn;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [31:0] memRdata;
  logic [31:0] perfIstall;
  logic [31:0] perfDstall;

  int assertCount = 0;
  int failCount   = 0;

  mem_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .MEM_LAT(LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ireq       (ireq),
    .iaddr      (iaddr),
    .irdata     (irdata),
    .iready     (iready),
    .istall     (istall),
    .dreq       (dreq),
    .dwe        (dwe),
    .daddr      (daddr),
    .dwdata     (dwdata),
    .drdata     (drdata),
    .dready     (dready),
    .dstall     (dstall),
    .mem_en     (memEn),
    .mem_we     (memWe),
    .mem_addr   (memAddr),
    .mem_wdata  (memWdata),
    .mem_rdata  (memRdata),
    .perf_istall(perfIstall),
    .perf_dstall(perfDstall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] initWord(input int idx);
    if (idx == 16) return 32'h8C010004;
    return 32'hA5000000 + idx;
  endfunction

  // Environment memory: word addressed, combinational read, write on strobe.
  logic [31:0] envMem [64];
  initial for (int i = 0; i < 64; i++) envMem[i] = initWord(i);
  assign memRdata = envMem[memAddr[7:2]];
  always @(posedge clk) begin
    if (memEn && memWe) envMem[memAddr[7:2]] <= memWdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a transaction granted in cycle t0 completes at t0+LAT+1 and frees the port at t0+LAT+2.
  logic [31:0] refMem [64];
  initial for (int i = 0; i < 64; i++) refMem[i] = initWord(i);

  int          cyc       = 0;
  int          freeCyc   = 0;
  int          doneCyc   = -1;
  bit          txIsD     = 1'b0;
  bit          txWe      = 1'b0;
  logic [31:0] txAddr    = '0;
  bit          lastD     = 1'b0;
  logic        expIready = 1'b0;
  logic        expDready = 1'b0;
  logic [31:0] expIrdata = '0;
  logic [31:0] expDrdata = '0;
  logic        expMemEn  = 1'b0;
  logic        expMemWe  = 1'b0;
  logic [31:0] expMemAddr  = '0;
  logic [31:0] expMemWdata = '0;
  logic [31:0] perfI = '0;
  logic [31:0] perfD = '0;

  always @(posedge clk) begin
    logic        sRst, sIreq, sDreq, sDwe;
    logic [31:0] sIaddr, sDaddr, sDwdata;
    bit          gD, gI;
    sRst = rst; sIreq = ireq; sDreq = dreq; sDwe = dwe;
    sIaddr = iaddr; sDaddr = daddr; sDwdata = dwdata;
    if (sRst) begin
      freeCyc = 0; doneCyc = -1; lastD = 1'b0;
      expIready = 0; expDready = 0; expIrdata = '0; expDrdata = '0;
      expMemEn = 0; expMemWe = 0; expMemAddr = '0; expMemWdata = '0;
      perfI = '0; perfD = '0;
    end else begin
      perfI = perfI + 32'(sIreq && !expIready);
      perfD = perfD + 32'(sDreq && !expDready);
      expIready = 0; expDready = 0; expMemEn = 0; expMemWe = 0;
      if (cyc == doneCyc) begin
        if (txIsD) begin
          expDready = 1;
          if (!txWe) expDrdata = refMem[txAddr[7:2]];
        end else begin
          expIready = 1;
          expIrdata = refMem[txAddr[7:2]];
        end
      end
      if (cyc >= freeCyc) begin
        gD = sDreq && (!sIreq || !lastD);
        gI = sIreq && !gD;
        if (gD || gI) begin
          doneCyc  = cyc + LAT;
          freeCyc  = cyc + LAT + 2;
          lastD    = gD;
          txIsD    = gD;
          txWe     = gD && sDwe;
          txAddr   = gD ? sDaddr : sIaddr;
          expMemEn = 1;
          expMemWe = txWe;
          expMemAddr = txAddr;
          if (gD) expMemWdata = sDwdata;
          if (txWe) refMem[txAddr[7:2]] = sDwdata;
        end
      end
    end
    cyc++;
    #1;
    checkOutput("iready", {31'b0, iready}, {31'b0, expIready});
    checkOutput("dready", {31'b0, dready}, {31'b0, expDready});
    checkOutput("irdata", irdata, expIrdata);
    checkOutput("drdata", drdata, expDrdata);
    checkOutput("mem_en", {31'b0, memEn}, {31'b0, expMemEn});
    checkOutput("mem_we", {31'b0, memWe}, {31'b0, expMemWe});
    checkOutput("mem_addr", memAddr, expMemAddr);
    checkOutput("mem_wdata", memWdata, expMemWdata);
    checkOutput("istall", {31'b0, istall}, {31'b0, ireq & ~expIready});
    checkOutput("dstall", {31'b0, dstall}, {31'b0, dreq & ~expDready});
`ifdef MEM_ARB_PERF_EN
    checkOutput("perf_istall", perfIstall, perfI);
    checkOutput("perf_dstall", perfDstall, perfD);
`else
    checkOutput("perf_istall", perfIstall, 32'h0);
    checkOutput("perf_dstall", perfDstall, 32'h0);
`endif
  end

  task automatic applyStimulus(input logic iq, input logic [31:0] ia, input logic dq,
                               input logic we, input logic [31:0] da, input logic [31:0] wd);
    @(negedge clk);
    ireq = iq; iaddr = ia; dreq = dq; dwe = we; daddr = da; dwdata = wd;
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #2;
  endtask

  int  evCyc [8];
  bit  evIsD [8];
  int  evN;
  bit  sawReady;

  initial begin
    rst = 1'b1; ireq = 0; iaddr = '0; dreq = 0; dwe = 0; daddr = '0; dwdata = '0;
    #1;
    checkOutput("reset_mem_en", {31'b0, memEn}, 32'h0);
    checkOutput("reset_iready", {31'b0, iready}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single fetch of the instruction word at 0x40.
    applyStimulus(1, 32'h40, 0, 0, 32'h0, 32'h0);
    afterEdge();
    checkOutput("fetch_mem_en", {31'b0, memEn}, 32'h1);
    checkOutput("fetch_mem_addr", memAddr, 32'h40);
    checkOutput("fetch_mem_we", {31'b0, memWe}, 32'h0);
    afterEdge();
    checkOutput("fetch_mem_en_pulse", {31'b0, memEn}, 32'h0);
    checkOutput("fetch_iready_early", {31'b0, iready}, 32'h0);
    afterEdge();
    checkOutput("fetch_iready", {31'b0, iready}, 32'h1);
    checkOutput("fetch_irdata", irdata, 32'h8C010004);
    checkOutput("fetch_istall_low", {31'b0, istall}, 32'h0);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0);
    afterEdge();
    checkOutput("fetch_iready_once", {31'b0, iready}, 32'h0);
`ifdef MEM_ARB_PERF_EN
    checkOutput("fetch_perf_istall", perfIstall, 32'(LAT + 1));
`else
    checkOutput("fetch_perf_istall", perfIstall, 32'h0);
`endif

    // Data write of 0x1234 to 0x80.
    applyStimulus(0, 32'h0, 1, 1, 32'h80, 32'h1234);
    afterEdge();
    checkOutput("write_mem_we", {31'b0, memWe}, 32'h1);
    checkOutput("write_mem_addr", memAddr, 32'h80);
    checkOutput("write_mem_wdata", memWdata, 32'h1234);
    afterEdge();
    checkOutput("write_dready_early", {31'b0, dready}, 32'h0);
    afterEdge();
    checkOutput("write_dready", {31'b0, dready}, 32'h1);
    checkOutput("write_drdata_held", drdata, 32'h0);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0);

    // Read back 0x80 while daddr changes during BUSY.
    applyStimulus(0, 32'h0, 1, 0, 32'h80, 32'h0);
    afterEdge();
    checkOutput("read_mem_addr", memAddr, 32'h80);
    @(negedge clk);
    daddr = 32'hC0;
    afterEdge();
    checkOutput("busy_mem_addr_held", memAddr, 32'h80);
    afterEdge();
    checkOutput("read_dready", {31'b0, dready}, 32'h1);
    checkOutput("read_drdata", drdata, 32'h1234);
    checkOutput("read_irdata_held", irdata, 32'h8C010004);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0);

    // Reset asserted one cycle into a read.
    applyStimulus(0, 32'h0, 1, 0, 32'h10, 32'h0);
    afterEdge();
    checkOutput("rstbusy_mem_en_pre", {31'b0, memEn}, 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("rstbusy_mem_en", {31'b0, memEn}, 32'h0);
    checkOutput("rstbusy_drdata", drdata, 32'h0);
    checkOutput("rstbusy_mem_addr", memAddr, 32'h0);
    checkOutput("rstbusy_dstall", {31'b0, dstall}, 32'h1);
    dreq = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sawReady = 1'b0;
    for (int k = 0; k < 6; k++) begin
      afterEdge();
      if (dready) sawReady = 1'b1;
    end
    checkOutput("rstbusy_no_dready", {31'b0, sawReady}, 32'h0);

    // Continuous contention from reset: D, I, D, I, every LAT+2 cycles.
    @(negedge clk);
    rst = 1'b1; ireq = 1; iaddr = 32'h40; dreq = 1; dwe = 0; daddr = 32'h80;
    @(negedge clk);
    rst = 1'b0;
    evN = 0;
    for (int k = 0; k < 4 * (LAT + 2) - 1; k++) begin
      afterEdge();
      if ((iready || dready) && evN < 8) begin
        evCyc[evN] = k;
        evIsD[evN] = dready;
        evN++;
      end
    end
    checkOutput("cont_events", 32'(evN), 32'h4);
    if (evN >= 4) begin
      checkOutput("cont_first_d", {31'b0, evIsD[0]}, 32'h1);
      checkOutput("cont_second_i", {31'b0, evIsD[1]}, 32'h0);
      checkOutput("cont_third_d", {31'b0, evIsD[2]}, 32'h1);
      checkOutput("cont_fourth_i", {31'b0, evIsD[3]}, 32'h0);
      checkOutput("cont_first_cycle", 32'(evCyc[0]), 32'(LAT));
      for (int k = 1; k < 4; k++)
        checkOutput("cont_spacing", 32'(evCyc[k] - evCyc[k-1]), 32'(LAT + 2));
    end
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
